// File: rtl/host_bridge_pkg.sv
// ============================================================================
// host_bridge_pkg
//   Shared encodings for the host bridge: ops, register offsets, FSM states.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package host_bridge_pkg;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_CYCLES  = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int CTRL_LOGIC_EN = 0;
    localparam int CTRL_CORE_RST = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/host_bridge_regs.sv
// ============================================================================
// host_bridge_regs
//   STATUS/CONTROL/CYCLES/SCRATCH register window with free-running counter.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module host_bridge_regs
    import host_bridge_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_halted,
    input  logic              i_wr_en,
    input  logic [1:0]        i_wr_sel,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [1:0]        i_rd_sel,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_logic_en,
    output logic              o_core_rst
);

    logic [1:0]        control_q, control_d;
    logic [DATA_W-1:0] cycles_q,  cycles_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;

    // A host write is applied after the increment so it overrides it.
    always_comb begin
        control_d = control_q;
        cycles_d  = cycles_q;
        scratch_d = scratch_q;
        if (control_q[CTRL_LOGIC_EN] && !i_halted) begin
            cycles_d = cycles_q + DATA_W'(1);
        end
        if (i_wr_en) begin
            case (i_wr_sel)
                REG_CONTROL: control_d = i_wr_data[1:0];
                REG_CYCLES:  cycles_d  = i_wr_data;
                REG_SCRATCH: scratch_d = i_wr_data;
                default:     ;
            endcase
        end
    end

    always_comb begin
        o_rd_data = '0;
        case (i_rd_sel)
            REG_STATUS:  o_rd_data[0]   = i_halted;
            REG_CONTROL: o_rd_data[1:0] = control_q;
            REG_CYCLES:  o_rd_data      = cycles_q;
            REG_SCRATCH: o_rd_data      = scratch_q;
            default:     o_rd_data      = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            control_q <= '0;
            cycles_q  <= '0;
            scratch_q <= '0;
        end else begin
            control_q <= control_d;
            cycles_q  <= cycles_d;
            scratch_q <= scratch_d;
        end
    end

    assign o_logic_en = control_q[CTRL_LOGIC_EN];
    assign o_core_rst = control_q[CTRL_CORE_RST];

endmodule

`default_nettype wire

// File: rtl/host_bridge.sv
// ============================================================================
// host_bridge
//   Valid/ready host bridge to memory port 0 and the core register window.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module host_bridge
    import host_bridge_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int MEM_ADDR_W  = 13,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_data,
    output logic                  o_rsp_err,
    output logic [1:0]            o_mem_op,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_data,
    input  logic [DATA_W-1:0]     i_mem_data,
    input  logic                  i_halted,
    output logic                  o_logic_en,
    output logic                  o_core_rst
);

    localparam int              LAT_W    = 4;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic [1:0]              mem_op_q, mem_op_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_data_q, mem_data_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic                    rd_pending_q, rd_pending_d;

    logic                    accept;
    logic                    is_reg;
    logic                    is_rw;
    logic                    req_err;
    logic                    reg_wr_en;
    logic [DATA_W-1:0]       reg_rd_data;

    assign accept = i_req_valid && req_ready_q;
    assign is_reg = i_req_addr[ADDR_W-1];
    assign is_rw  = (i_req_op == OP_READ) || (i_req_op == OP_WRITE);

    // NOPs never fault on address; only real accesses are range-checked.
    assign req_err = (i_req_op == OP_RSVD) ||
                     (is_rw && (is_reg ? (|i_req_addr[ADDR_W-2:2])
                                       : (|i_req_addr[ADDR_W-2:MEM_ADDR_W])));

    assign reg_wr_en = accept && !req_err && is_reg && (i_req_op == OP_WRITE);

    host_bridge_regs #(
        .DATA_W (DATA_W)
    ) u_regs (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_halted   (i_halted),
        .i_wr_en    (reg_wr_en),
        .i_wr_sel   (i_req_addr[1:0]),
        .i_wr_data  (i_req_data),
        .i_rd_sel   (i_req_addr[1:0]),
        .o_rd_data  (reg_rd_data),
        .o_logic_en (o_logic_en),
        .o_core_rst (o_core_rst)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        mem_op_d     = OP_NOP;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        lat_cnt_d    = lat_cnt_q;
        rd_pending_d = rd_pending_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d  = 1'b0;
                    rsp_data_d   = '0;
                    rsp_err_d    = req_err;
                    rd_pending_d = 1'b0;
                    if (!req_err && !is_reg && is_rw) begin
                        mem_op_d   = i_req_op;
                        mem_addr_d = i_req_addr[MEM_ADDR_W-1:0];
                        if (i_req_op == OP_WRITE) begin
                            mem_data_d = i_req_data;
                            lat_cnt_d  = '0;
                        end else begin
                            lat_cnt_d    = LAT_LOAD;
                            rd_pending_d = 1'b1;
                        end
                        state_d = MEM_WAIT;
                    end else begin
                        if (!req_err && is_reg && (i_req_op == OP_READ)) begin
                            rsp_data_d = reg_rd_data;
                        end
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            // First edge here is the one at which memory samples the op.
            MEM_WAIT: begin
                if (lat_cnt_q == '0) begin
                    if (rd_pending_q) begin
                        rsp_data_d = i_mem_data;
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            mem_op_q     <= OP_NOP;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            lat_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            mem_op_q     <= mem_op_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            lat_cnt_q    <= lat_cnt_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_mem_op    = mem_op_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;

endmodule

`default_nettype wire

// File: tb/tb_host_bridge.sv
// ============================================================================
// tb_host_bridge
//   Directed bench: two bridges (memory latency 1 and 3) with a memory model.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_host_bridge;
    import host_bridge_pkg::*;

    localparam logic [63:0] JUNK = 64'h5A5A_0BAD_0BAD_5A5A;
    localparam logic [63:0] RWIN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op    [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_data  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic [1:0]  mem_op    [2];
    logic [12:0] mem_addr  [2];
    logic [63:0] mem_wdata [2];
    logic [63:0] mem_rdata [2];
    logic        halted    [2];
    logic        logic_en  [2];
    logic        core_rst  [2];

    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    logic [63:0] mem0 [8192];
    logic [63:0] pipe0;
    logic [63:0] pipe1 [3];

    host_bridge #(.DATA_W(64), .ADDR_W(64), .MEM_ADDR_W(13), .MEM_LATENCY(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_op(req_op[0]), .i_req_addr(req_addr[0]), .i_req_data(req_data[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0]),
        .o_mem_op(mem_op[0]), .o_mem_addr(mem_addr[0]), .o_mem_data(mem_wdata[0]),
        .i_mem_data(mem_rdata[0]), .i_halted(halted[0]),
        .o_logic_en(logic_en[0]), .o_core_rst(core_rst[0])
    );

    host_bridge #(.DATA_W(64), .ADDR_W(64), .MEM_ADDR_W(13), .MEM_LATENCY(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_op(req_op[1]), .i_req_addr(req_addr[1]), .i_req_data(req_data[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1]),
        .o_mem_op(mem_op[1]), .o_mem_addr(mem_addr[1]), .o_mem_data(mem_wdata[1]),
        .i_mem_data(mem_rdata[1]), .i_halted(halted[1]),
        .o_logic_en(logic_en[1]), .o_core_rst(core_rst[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a READ sampled at an edge is visible LATENCY edges later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_op[0] == OP_WRITE) mem0[mem_addr[0]] <= mem_wdata[0];
        pipe0    <= (mem_op[0] == OP_READ) ? mem0[mem_addr[0]] : JUNK;
        pipe1[0] <= (mem_op[1] == OP_READ) ? (64'hCAFE_0000_0000_0000 | 64'(mem_addr[1])) : JUNK;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    always_comb begin
        mem_rdata[0] = pipe0;
        mem_rdata[1] = pipe1[2];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic [1:0] op, input logic [63:0] addr,
                        input logic [63:0] data, output int acc);
        int n = 0;
        while (!req_ready[s] && n < 30) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 64'(req_ready[s]), 64'd1);
        req_valid[s] = 1'b1;
        req_op[s]    = op;
        req_addr[s]  = addr;
        req_data[s]  = data;
        tick();
        acc          = cyc;
        req_valid[s] = 1'b0;
        req_op[s]    = OP_NOP;
    endtask

    task automatic push(input logic [63:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Entered one cycle after the accepting edge; lat counts from there.
    task automatic expect_rsp(input int s, input int lat, input string tag);
        exp_t e;
        int   n = 1;
        while (!rsp_valid[s] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_sb: observed response expected none queued", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"}, rsp_data[s], e.data);
        chk({tag, "_err"}, 64'(rsp_err[s]), 64'(e.err));
        if (rsp_ready[s]) begin
            tick();
            chk({tag, "_vld_drop"}, 64'(rsp_valid[s]), 64'd0);
            chk({tag, "_rdy_back"}, 64'(req_ready[s]), 64'd1);
        end
    endtask

    initial begin
        int k1;
        int k2;
        int acc;
        logic quiet_bad;

        for (int s = 0; s < 2; s++) begin
            rst[s]       = 1'b1;
            req_valid[s] = 1'b0;
            req_op[s]    = OP_NOP;
            req_addr[s]  = '0;
            req_data[s]  = '0;
            rsp_ready[s] = 1'b1;
            halted[s]    = 1'b0;
        end
        repeat (3) tick();

        chk("rst_req_ready", 64'(req_ready[0]), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_rsp_data",  rsp_data[0], 64'd0);
        chk("rst_rsp_err",   64'(rsp_err[0]), 64'd0);
        chk("rst_mem_op",    64'(mem_op[0]), 64'(OP_NOP));
        chk("rst_mem_addr",  64'(mem_addr[0]), 64'd0);
        chk("rst_mem_data",  mem_wdata[0], 64'd0);
        chk("rst_logic_en",  64'(logic_en[0]), 64'd0);
        chk("rst_core_rst",  64'(core_rst[0]), 64'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        chk("post_rst_ready", 64'(req_ready[0]), 64'd1);

        // ---- Memory, latency 1 ----
        send(0, OP_WRITE, 64'h10, 64'hDEAD_BEEF, acc);
        chk("wr_mem_op",   64'(mem_op[0]), 64'(OP_WRITE));
        chk("wr_mem_addr", 64'(mem_addr[0]), 64'h10);
        chk("wr_mem_data", mem_wdata[0], 64'hDEAD_BEEF);
        push(64'd0, 1'b0);
        expect_rsp(0, 2, "wr10");
        chk("wr_mem_op_nop", 64'(mem_op[0]), 64'(OP_NOP));

        send(0, OP_READ, 64'h10, 64'd0, acc);
        chk("rd_mem_op", 64'(mem_op[0]), 64'(OP_READ));
        push(64'hDEAD_BEEF, 1'b0);
        expect_rsp(0, 3, "rd10");

        // ---- Register window ----
        send(0, OP_WRITE, RWIN | 64'd1, 64'h3, acc);
        chk("ctl_logic_en", 64'(logic_en[0]), 64'd1);
        chk("ctl_core_rst", 64'(core_rst[0]), 64'd1);
        push(64'd0, 1'b0);
        expect_rsp(0, 1, "ctl_wr");

        send(0, OP_WRITE, RWIN | 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, acc);
        push(64'd0, 1'b0);
        expect_rsp(0, 1, "ctl_wr_all");
        send(0, OP_READ, RWIN | 64'd1, 64'd0, acc);
        push(64'h3, 1'b0);
        expect_rsp(0, 1, "ctl_rd");

        send(0, OP_WRITE, RWIN | 64'd2, 64'd0, k1);
        push(64'd0, 1'b0);
        expect_rsp(0, 1, "cyc_clr");
        repeat (8) tick();
        send(0, OP_READ, RWIN | 64'd2, 64'd0, k2);
        push(64'(k2 - k1 - 1), 1'b0);
        expect_rsp(0, 1, "cyc_rd10");

        // Write lands while the counter is running; wrap follows.
        send(0, OP_WRITE, RWIN | 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, k1);
        push(64'd0, 1'b0);
        expect_rsp(0, 1, "cyc_wr_max");
        send(0, OP_READ, RWIN | 64'd2, 64'd0, k2);
        push(64'hFFFF_FFFF_FFFF_FFFF + 64'(k2 - k1 - 1), 1'b0);
        expect_rsp(0, 1, "cyc_wrap");

        send(0, OP_WRITE, RWIN | 64'd3, 64'h0123_4567_89AB_CDEF, acc);
        push(64'd0, 1'b0);
        expect_rsp(0, 1, "scr_wr");
        send(0, OP_READ, RWIN | 64'd3, 64'd0, acc);
        push(64'h0123_4567_89AB_CDEF, 1'b0);
        expect_rsp(0, 1, "scr_rd");

        halted[0] = 1'b1;
        send(0, OP_READ, RWIN, 64'd0, acc);
        push(64'h1, 1'b0);
        expect_rsp(0, 1, "status_rd");

        // ---- Errors and NOP ----
        send(0, OP_RSVD, 64'h10, 64'h55, acc);
        chk("op3_mem_op", 64'(mem_op[0]), 64'(OP_NOP));
        push(64'd0, 1'b1);
        expect_rsp(0, 1, "op3");

        send(0, OP_READ, RWIN | 64'd4, 64'd0, acc);
        push(64'd0, 1'b1);
        expect_rsp(0, 1, "reg_off4");

        send(0, OP_READ, 64'h2000, 64'd0, acc);
        chk("oob_mem_op", 64'(mem_op[0]), 64'(OP_NOP));
        push(64'd0, 1'b1);
        expect_rsp(0, 1, "mem_oob");

        send(0, OP_NOP, 64'h20, 64'h77, acc);
        chk("nop_mem_op", 64'(mem_op[0]), 64'(OP_NOP));
        push(64'd0, 1'b0);
        expect_rsp(0, 1, "nop");

        // ---- Memory, latency 3, held response ----
        rsp_ready[1] = 1'b0;
        send(1, OP_READ, 64'h1FFF, 64'd0, acc);
        chk("l3_mem_op",   64'(mem_op[1]), 64'(OP_READ));
        chk("l3_mem_addr", 64'(mem_addr[1]), 64'h1FFF);
        push(64'hCAFE_0000_0000_1FFF, 1'b0);
        expect_rsp(1, 5, "l3_rd");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 64'(rsp_valid[1]), 64'd1);
            chk("hold_data",  rsp_data[1], 64'hCAFE_0000_0000_1FFF);
            chk("hold_ready", 64'(req_ready[1]), 64'd0);
        end
        rsp_ready[1] = 1'b1;
        tick();
        chk("hold_release_valid", 64'(rsp_valid[1]), 64'd0);
        chk("hold_release_ready", 64'(req_ready[1]), 64'd1);

        // ---- Reset during MEM_WAIT ----
        send(1, OP_WRITE, RWIN | 64'd1, 64'h3, acc);
        push(64'd0, 1'b0);
        expect_rsp(1, 1, "l3_ctl");
        chk("l3_logic_en_set", 64'(logic_en[1]), 64'd1);
        send(1, OP_READ, 64'h5, 64'd0, acc);
        chk("l3b_mem_op", 64'(mem_op[1]), 64'(OP_READ));
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("mid_rst_valid",    64'(rsp_valid[1]), 64'd0);
        chk("mid_rst_mem_op",   64'(mem_op[1]), 64'(OP_NOP));
        chk("mid_rst_logic_en", 64'(logic_en[1]), 64'd0);
        chk("mid_rst_core_rst", 64'(core_rst[1]), 64'd0);
        quiet_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid[1]) quiet_bad = 1'b1;
        end
        chk("mid_rst_no_rsp", 64'(quiet_bad), 64'd0);

        send(1, OP_READ, RWIN | 64'd1, 64'd0, acc);
        push(64'd0, 1'b0);
        expect_rsp(1, 1, "mid_rst_ctl_rd");
        send(1, OP_READ, 64'h1FFF, 64'd0, acc);
        push(64'hCAFE_0000_0000_1FFF, 1'b0);
        expect_rsp(1, 5, "post_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
